// File: rtl/rcv_drain_ctrl.sv
// rcv_drain_ctrl
// Host-side controller for the UART receive block.
// - Drains bytes from the receiver's single-entry buffer into a local FIFO
//   using the data_ready / data_read handshake (two-state drain FSM).
// - Owns the receiver's bit_period / data_size; host updates are shadowed
//   and applied only while the receiver is idle (between packets).
// - Optional receive-error event counters, built only when the macro
//   RCV_ERRCNT_EN is defined; otherwise ovr_cnt / frm_cnt are tied to 0.
//
// Ports:
//   clk, n_rst                   clock, asynchronous active-low reset
//   rx_data, data_ready          receiver buffer contents / byte-valid
//   overrun_error, framing_error receiver error flags (levels)
//   rx_busy                      receiver is mid-packet
//   data_read                    one-cycle acknowledge to receiver
//   bit_period, data_size        applied receiver configuration
//   cfg_wr, cfg_bit_period,
//   cfg_data_size, cfg_pending   host config request / pending flag
//   pop, fifo_data, fifo_empty,
//   fifo_full, fifo_count        host side of the FIFO
//   ovr_cnt, frm_cnt             overrun / framing event counters
module rcv_drain_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [7:0]                 rx_data,
    input  logic                       data_ready,
    input  logic                       overrun_error,
    input  logic                       framing_error,
    input  logic                       rx_busy,
    output logic                       data_read,
    output logic [13:0]                bit_period,
    output logic [3:0]                 data_size,
    input  logic                       cfg_wr,
    input  logic [13:0]                cfg_bit_period,
    input  logic [3:0]                 cfg_data_size,
    output logic                       cfg_pending,
    input  logic                       pop,
    output logic [7:0]                 fifo_data,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           ovr_cnt,
    output logic [CNT_W-1:0]           frm_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // ---------------- drain FSM ----------------
    logic [0:0] state_reg;
    logic       push;
    logic       pop_ok;
    logic       full_reg;
    logic       empty_reg;

    // A pop in the same cycle as a full FIFO does not enable a push here;
    // the freed slot is seen on the next IDLE evaluation.
    assign push   = (state_reg == ST_IDLE) && data_ready && !full_reg;
    assign pop_ok = pop && !empty_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else if (state_reg == ST_ACK) begin
            state_reg <= ST_IDLE;
        end else if (push) begin
            state_reg <= ST_ACK;
        end
    end

    assign data_read = (state_reg == ST_ACK);

    // ---------------- FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    head_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_next;
    logic [7:0]    head_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= rx_data;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop_ok);
        // The head register must show the entry at the new read pointer.
        // If that slot is being written this very edge, bypass from rx_data.
        if (count_next == '0) begin
            head_next = head_reg;
        end else if (push && (rd_ptr_next == wr_ptr_reg)) begin
            head_next = rx_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            count_reg  <= count_next;
            head_reg   <= head_next;
            empty_reg  <= (count_next == '0);
            full_reg   <= (count_next == (AW+1)'(DEPTH));
        end
    end

    assign fifo_data  = head_reg;
    assign fifo_empty = empty_reg;
    assign fifo_full  = full_reg;
    assign fifo_count = count_reg;

    // ---------------- configuration ----------------
    logic [13:0] shadow_bp_reg;
    logic [3:0]  shadow_ds_reg;
    logic [13:0] bit_period_reg;
    logic [3:0]  data_size_reg;
    logic        pending_reg;
    logic [13:0] bp_clamped;
    logic [3:0]  ds_clamped;
    logic        apply;

    always_comb begin
        bp_clamped = (cfg_bit_period < 14'd2) ? 14'd2 : cfg_bit_period;
        if (cfg_data_size < 4'd5) begin
            ds_clamped = 4'd5;
        end else if (cfg_data_size > 4'd8) begin
            ds_clamped = 4'd8;
        end else begin
            ds_clamped = cfg_data_size;
        end
    end

    // Apply uses the shadow as it stood before this edge; a simultaneous
    // cfg_wr re-arms pending so the newer value is applied later.
    assign apply = pending_reg && !rx_busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shadow_bp_reg  <= 14'd10;
            shadow_ds_reg  <= 4'd8;
            bit_period_reg <= 14'd10;
            data_size_reg  <= 4'd8;
            pending_reg    <= 1'b0;
        end else begin
            if (apply) begin
                bit_period_reg <= shadow_bp_reg;
                data_size_reg  <= shadow_ds_reg;
            end
            if (cfg_wr) begin
                shadow_bp_reg <= bp_clamped;
                shadow_ds_reg <= ds_clamped;
                pending_reg   <= 1'b1;
            end else if (apply) begin
                pending_reg   <= 1'b0;
            end
        end
    end

    assign bit_period  = bit_period_reg;
    assign data_size   = data_size_reg;
    assign cfg_pending = pending_reg;

    // ---------------- error counters ----------------
`ifdef RCV_ERRCNT_EN
    logic             ovr_d_reg;
    logic             frm_d_reg;
    logic [CNT_W-1:0] ovr_cnt_reg;
    logic [CNT_W-1:0] frm_cnt_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovr_d_reg   <= 1'b0;
            frm_d_reg   <= 1'b0;
            ovr_cnt_reg <= '0;
            frm_cnt_reg <= '0;
        end else begin
            ovr_d_reg <= overrun_error;
            frm_d_reg <= framing_error;
            // Count rising edges only; saturate at all-ones.
            if (overrun_error && !ovr_d_reg && (ovr_cnt_reg != '1)) begin
                ovr_cnt_reg <= ovr_cnt_reg + 1'b1;
            end
            if (framing_error && !frm_d_reg && (frm_cnt_reg != '1)) begin
                frm_cnt_reg <= frm_cnt_reg + 1'b1;
            end
        end
    end

    assign ovr_cnt = ovr_cnt_reg;
    assign frm_cnt = frm_cnt_reg;
`else
    logic unused_err;
    assign unused_err = overrun_error ^ framing_error;
    assign ovr_cnt    = '0;
    assign frm_cnt    = '0;
`endif

endmodule

// File: doc/rcv_drain_ctrl.md
# rcv_drain_ctrl

Host-side controller for the UART receive block. Drains received bytes from the receiver's single-entry data buffer into a local FIFO using the `data_ready`/`data_read` handshake. Owns the receiver's `bit_period`/`data_size` configuration and applies host updates only between packets. Optionally counts receive errors. Sits between the receive block and the host/bus logic.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 8, error counter width

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  8  receiver data buffer contents
- data_ready  in  1  receiver buffer holds an unread byte
- overrun_error  in  1  receiver overrun flag (level)
- framing_error  in  1  receiver framing flag (level)
- rx_busy  in  1  receiver is mid-packet (timer enabled)
- data_read  out  1  one-cycle acknowledge to receiver buffer
- bit_period  out  14  applied bit period to receiver
- data_size  out  4  applied data size to receiver
- cfg_wr  in  1  host config write strobe
- cfg_bit_period  in  14  requested bit period
- cfg_data_size  in  4  requested data size
- cfg_pending  out  1  config latched, not yet applied
- pop  in  1  host reads FIFO head
- fifo_data  out  8  FIFO head (valid when !fifo_empty)
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- ovr_cnt  out  CNT_W  overrun event count
- frm_cnt  out  CNT_W  framing event count

## Operation
- Drain FSM has two states: IDLE and ACK.
  - IDLE: if data_ready && !fifo_full → write rx_data into FIFO at this edge, go to ACK.
  - ACK: data_read=1 (decoded from state) → IDLE unconditionally.
  - data_ready high with FIFO full: stay in IDLE, no data_read. The byte stays in the receiver; further packets may raise overrun_error there.
- FIFO pointers wrap modulo DEPTH.
  - pop on empty is ignored.
  - Push and pop in the same cycle: both happen, count unchanged. When full, a pop frees the slot for a push on the next IDLE evaluation only.
  - fifo_data is the registered head entry.
- Config:
  - cfg_wr latches cfg_* into shadow registers and sets cfg_pending.
  - On the first edge with cfg_pending && !rx_busy, shadow values copy to bit_period/data_size and cfg_pending clears.
  - cfg_wr while pending overwrites the shadow.
  - cfg_wr in the same cycle as apply: the new value is latched and cfg_pending stays 1.
  - data_size is clamped on latch: <5 → 5, >8 → 8.
  - bit_period 0 or 1 is clamped to 2.
- Reset, including mid-packet or mid-handshake:
  - FSM → IDLE; FIFO flushed.
  - cfg_pending=0, bit_period=14'd10, data_size=4'd8.
  - data_read=0, fifo_empty=1, fifo_full=0, fifo_count=0, fifo_data=0, counters=0.

## Timing
- data_ready sampled high at edge N (IDLE, not full): byte written at N; fifo_empty=0 and data_read=1 during cycle N..N+1; IDLE again after N+1.
- Throughput: 1 byte per 2 cycles.
- Pop at edge M: fifo_data shows the next entry after M.
- Config apply latency: 1 cycle after cfg_wr if rx_busy=0; otherwise the first edge after rx_busy falls.
- All outputs are registered except data_read (state decode).

## Configuration
- RCV_ERRCNT_EN defined:
  - ovr_cnt/frm_cnt increment on the rising edge of overrun_error/framing_error, detected with one registered copy of each flag.
  - Counters saturate at all-ones.
- RCV_ERRCNT_EN undefined: ovr_cnt and frm_cnt are tied to 0 and no edge-detect flops are built.

## Test plan
- Reset, then data_ready=1 with rx_data=8'hA5: data_read is high for exactly 1 cycle one cycle later; fifo_data=8'hA5; fifo_count=1.
- Push 8 bytes 8'h01..8'h08 with no pop (DEPTH=8): fifo_full=1. A 9th data_ready stays unacked (data_read=0) until one pop; then 8'h01 is popped and the 9th byte enters.
- Simultaneous pop and push at count 4: count stays 4 and order is preserved. Pop on empty: no change, count 0.
- cfg_wr with bit_period 14'd868, data_size 4'd7 while rx_busy=1: cfg_pending=1, outputs unchanged. After rx_busy falls, outputs are 868/7 one edge later and cfg_pending=0. cfg_data_size 4'd12 applies as 8.
- With RCV_ERRCNT_EN: 3 framing_error pulses plus a 10-cycle-long framing_error level give frm_cnt=4. At CNT_W=2, 5 overrun pulses give ovr_cnt=3.
- Assert n_rst mid-ACK with 3 bytes queued: data_read=0, fifo_empty=1, bit_period=10, data_size=8 immediately, without waiting for a clock edge.
